// File: rtl/bit_serializer_fifo.sv
// bit_serializer_fifo
// Word-in / bit-out FIFO that feeds the constant-weight encoder core.
// Words of IN_W bits are written on one side. They are read back one bit per
// accepted rd_en, in MSB-first or LSB-first order. The block also provides
// frame marking (last / frame_done) and sticky overflow/underflow flags.
// Optional feature macro: SER_LEVEL_EN. When it is defined, the
// wr_word_count / rd_bit_count level ports are live. When it is undefined,
// both ports are tied to zero.
module bit_serializer_fifo #(
  parameter int IN_W       = 8,
  parameter int DEPTH      = 32,
  parameter int FRAME_BITS = 256,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         start,
  input  logic [IN_W-1:0]              din,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic                         dout,
  output logic                         dout_vld,
  output logic                         last,
  output logic                         frame_done,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         udf,
  output logic [$clog2(DEPTH):0]       wr_word_count,
  output logic [$clog2(DEPTH*IN_W):0]  rd_bit_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int BW    = (IN_W > 1) ? $clog2(IN_W) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [BW-1:0]    BIT_ONE    = BW'(1);
  localparam logic [BW-1:0]    BIT_LAST   = BW'(IN_W - 1);
  localparam logic [15:0]      FRAME_LAST = 16'(FRAME_BITS - 1);

  // Word storage; no reset so it maps onto plain RAM.
  logic [IN_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [BW-1:0]    bit_idx_reg, bit_idx_next;
  logic [15:0]      frame_cnt_reg, frame_cnt_next;
  logic [15:0]      frame_base;
  logic             dout_reg, dout_next;
  logic             dout_vld_reg, dout_vld_next;
  logic             last_reg, last_next;
  logic             ovf_reg, ovf_next;
  logic             udf_reg, udf_next;

  logic [IN_W-1:0]  head_word;
  logic [IN_W-1:0]  head_ord;
  logic             full_int;
  logic             empty_int;
  logic             wr_ok;
  logic             rd_ok;

  // Head word of the queue. It is selected from the registered read pointer.
  assign head_word = mem[rd_ptr_reg[PW-1:0]];

  // Reorder the head word so that index bit_idx is always the next bit to send.
  // The delivery order then costs no logic in the read path.
  genvar gi;
  generate
    for (gi = 0; gi < IN_W; gi++) begin : g_order
      if (MSB_FIRST) begin : g_msb
        assign head_ord[gi] = head_word[IN_W-1-gi];
      end else begin : g_lsb
        assign head_ord[gi] = head_word[gi];
      end
    end
  endgenerate

`ifdef SER_LEVEL_EN
  logic [PTR_W-1:0]                word_cnt;
  logic [$clog2(DEPTH*IN_W):0]     bit_cnt;

  // Occupancy levels. A partially read head word still holds its slot.
  always_comb begin
    word_cnt = wr_ptr_reg - rd_ptr_reg;
    bit_cnt  = ($clog2(DEPTH*IN_W)+1)'(word_cnt) * ($clog2(DEPTH*IN_W)+1)'(IN_W)
             - ($clog2(DEPTH*IN_W)+1)'(bit_idx_reg);
  end

  assign full_int      = (word_cnt == PTR_W'(DEPTH));
  assign empty_int     = (bit_cnt == '0);
  assign wr_word_count = word_cnt;
  assign rd_bit_count  = bit_cnt;
`else
  // Pointer-only comparisons. bit_idx is nonzero only while a head word exists,
  // so equal pointers already imply that no unread bit is left.
  assign full_int      = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                         (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign empty_int     = (wr_ptr_reg == rd_ptr_reg);
  assign wr_word_count = '0;
  assign rd_bit_count  = '0;
`endif

  // Legality uses only this cycle's registers. There is no write-through-read
  // bypass, and a same-cycle read does not free a slot for a write.
  assign wr_ok = wr_en & ~full_int;
  assign rd_ok = rd_en & ~empty_int;

  // Store an accepted write word at the tail.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[PW-1:0]] <= din;
    end
  end

  // Next-state logic for pointers, bit cursor, framing and sticky flags.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    bit_idx_next   = bit_idx_reg;
    dout_next      = dout_reg;
    dout_vld_next  = 1'b0;
    last_next      = 1'b0;
    // start restarts the frame. A read in the same cycle becomes bit 1 of the new frame.
    frame_base     = start ? 16'd0 : frame_cnt_reg;
    frame_cnt_next = frame_base;
    ovf_next       = start ? 1'b0 : ovf_reg;
    udf_next       = start ? 1'b0 : udf_reg;

    // An offending request in the same cycle as start still sets the flag.
    if (wr_en && full_int) begin
      ovf_next = 1'b1;
    end
    if (rd_en && empty_int) begin
      udf_next = 1'b1;
    end

    if (wr_ok) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end

    if (rd_ok) begin
      dout_next     = head_ord[bit_idx_reg];
      dout_vld_next = 1'b1;
      if (bit_idx_reg == BIT_LAST) begin
        bit_idx_next = '0;
        rd_ptr_next  = rd_ptr_reg + PTR_ONE;
      end else begin
        bit_idx_next = bit_idx_reg + BIT_ONE;
      end
      if (frame_base == FRAME_LAST) begin
        frame_cnt_next = 16'd0;
        last_next      = 1'b1;
      end else begin
        frame_cnt_next = frame_base + 16'd1;
      end
    end
  end

  // State and output registers. Reset clears everything except RAM contents,
  // which become unreachable once the pointers are zeroed.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      bit_idx_reg   <= '0;
      frame_cnt_reg <= 16'd0;
      dout_reg      <= 1'b0;
      dout_vld_reg  <= 1'b0;
      last_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      udf_reg       <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      bit_idx_reg   <= bit_idx_next;
      frame_cnt_reg <= frame_cnt_next;
      dout_reg      <= dout_next;
      dout_vld_reg  <= dout_vld_next;
      last_reg      <= last_next;
      ovf_reg       <= ovf_next;
      udf_reg       <= udf_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_vld   = dout_vld_reg;
  assign last       = last_reg;
  assign frame_done = last_reg;
  assign full       = full_int;
  assign empty      = empty_int;
  assign ovf        = ovf_reg;
  assign udf        = udf_reg;

endmodule

// File: tb/tb_bit_serializer_fifo.sv
// Testbench for bit_serializer_fifo.
// Two instances receive the same stimulus. One uses MSB_FIRST=1 and the other
// MSB_FIRST=0. Both are checked against a bit-queue reference model, a vector
// table, and hand-written corner-case sequences.
module tb_bit_serializer_fifo;

  localparam int IN_W  = 8;
  localparam int DEPTH = 32;
  localparam int FB    = 16;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic start = 1'b0;
  logic [7:0] din = 8'h00;
  logic wr_en = 1'b0;
  logic rd_en = 1'b0;

  logic dout_m, vld_m, last_m, fd_m, full_m, empty_m, ovf_m, udf_m;
  logic dout_l, vld_l, last_l, fd_l, full_l, empty_l, ovf_l, udf_l;
  logic [5:0] wc_m, wc_l;
  logic [8:0] bc_m, bc_l;

  always #5 clk = ~clk;

  bit_serializer_fifo #(.IN_W(IN_W), .DEPTH(DEPTH), .FRAME_BITS(FB), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_b(rst_b), .start(start), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_m), .dout_vld(vld_m), .last(last_m), .frame_done(fd_m), .full(full_m),
    .empty(empty_m), .ovf(ovf_m), .udf(udf_m), .wr_word_count(wc_m), .rd_bit_count(bc_m));

  bit_serializer_fifo #(.IN_W(IN_W), .DEPTH(DEPTH), .FRAME_BITS(FB), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_b(rst_b), .start(start), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout_l), .dout_vld(vld_l), .last(last_l), .frame_done(fd_l), .full(full_l),
    .empty(empty_l), .ovf(ovf_l), .udf(udf_l), .wr_word_count(wc_l), .rd_bit_count(bc_l));

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  // Reference model: each order keeps a queue of the bits still to be delivered.
  bit qm[$];
  bit ql[$];
  int fcnt;
  logic e_dm, e_dl, e_vld, e_last, e_ovf, e_udf;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       dm;
    logic       dl;
    logic       vld;
    logic       last;
    logic       empty;
    logic       udf;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qm.delete();
    ql.delete();
    fcnt   = 0;
    e_dm   = 1'b0;
    e_dl   = 1'b0;
    e_vld  = 1'b0;
    e_last = 1'b0;
    e_ovf  = 1'b0;
    e_udf  = 1'b0;
  endtask

  function automatic int words_held();
    return (qm.size() + IN_W - 1) / IN_W;
  endfunction

  task automatic check_all();
    int wexp;
    int bexp;
`ifdef SER_LEVEL_EN
    wexp = words_held();
    bexp = qm.size();
`else
    wexp = 0;
    bexp = 0;
`endif
    chk("dout_msb", {31'b0, dout_m}, {31'b0, e_dm});
    chk("dout_lsb", {31'b0, dout_l}, {31'b0, e_dl});
    chk("dout_vld", {30'b0, vld_l, vld_m}, {30'b0, e_vld, e_vld});
    chk("last", {29'b0, fd_m, last_l, last_m}, {29'b0, e_last, e_last, e_last});
    chk("full", {30'b0, full_l, full_m}, {30'b0, {2{words_held() == DEPTH}}});
    chk("empty", {30'b0, empty_l, empty_m}, {30'b0, {2{qm.size() == 0}}});
    chk("ovf", {30'b0, ovf_l, ovf_m}, {30'b0, e_ovf, e_ovf});
    chk("udf", {30'b0, udf_l, udf_m}, {30'b0, e_udf, e_udf});
    chk("wr_word_count", {26'b0, wc_m}, wexp);
    chk("rd_bit_count", {23'b0, bc_m}, bexp);
  endtask

  // One clock of stimulus. The model advances, then all outputs are checked
  // 1 time unit after the edge.
  task automatic step(input logic s, input logic w, input logic [7:0] d, input logic r);
    bit full_pre;
    bit empty_pre;
    start = s;
    wr_en = w;
    din   = d;
    rd_en = r;
    full_pre  = (words_held() == DEPTH);
    empty_pre = (qm.size() == 0);
    if (s) begin
      fcnt  = 0;
      e_ovf = 1'b0;
      e_udf = 1'b0;
    end
    if (w && full_pre)  e_ovf = 1'b1;
    if (r && empty_pre) e_udf = 1'b1;
    e_vld  = 1'b0;
    e_last = 1'b0;
    if (r && !empty_pre) begin
      e_dm  = qm.pop_front();
      e_dl  = ql.pop_front();
      e_vld = 1'b1;
      fcnt++;
      if (fcnt == FB) begin
        e_last = 1'b1;
        fcnt   = 0;
      end
    end
    if (w && !full_pre) begin
      for (int k = 0; k < IN_W; k++) begin
        qm.push_back(d[IN_W-1-k]);
        ql.push_back(d[k]);
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_txn++;
    $display("txn %0d: s=%0b w=%0b d=%02h r=%0b -> dout=%0b/%0b vld=%0b last=%0b full=%0b empty=%0b ovf=%0b udf=%0b",
             n_txn, s, w, d, r, dout_m, dout_l, vld_m, last_m, full_m, empty_m, ovf_m, udf_m);
    check_all();
  endtask

  task automatic do_reset();
    start = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic fill_table();
    logic [7:0] a5;
    logic [7:0] c8;
    a5 = 8'hA5;
    c8 = 8'hC8;
    tbl[0] = '{1'b1, a5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[1+k] = '{1'b0, 8'h00, 1'b1, a5[7-k], a5[k], 1'b1, 1'b0, (k == 7), 1'b0};
    tbl[9] = '{1'b1, c8, 1'b0, a5[0], a5[7], 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[10+k] = '{1'b0, 8'h00, 1'b1, c8[7-k], c8[k], 1'b1, (k == 7), (k == 7), 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b1, c8[0], c8[7], 1'b0, 1'b0, 1'b1, 1'b1};
  endtask

  initial begin
    int lc;
    int lpos;
    int wp;
    int rp;
    model_reset();

    // Reset values while rst_b is held low.
    #1;
    chk("rst_dout", {31'b0, dout_m}, 32'd0);
    chk("rst_vld", {31'b0, vld_m}, 32'd0);
    chk("rst_last", {30'b0, fd_m, last_m}, 32'd0);
    chk("rst_full", {31'b0, full_m}, 32'd0);
    chk("rst_empty", {31'b0, empty_m}, 32'd1);
    chk("rst_flags", {30'b0, ovf_m, udf_m}, 32'd0);
    chk("rst_counts", {17'b0, bc_m, wc_m}, 32'd0);
    do_reset();

    // Vector table: 0xA5 then 0xC8, read out in both orders.
    fill_table();
    for (int i = 0; i < 19; i++) begin
      step(1'b0, tbl[i].w, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_dout_msb", i), {31'b0, dout_m}, {31'b0, tbl[i].dm});
      chk($sformatf("tbl%0d_dout_lsb", i), {31'b0, dout_l}, {31'b0, tbl[i].dl});
      chk($sformatf("tbl%0d_vld", i), {31'b0, vld_m}, {31'b0, tbl[i].vld});
      chk($sformatf("tbl%0d_last", i), {31'b0, last_m}, {31'b0, tbl[i].last});
      chk($sformatf("tbl%0d_empty", i), {31'b0, empty_m}, {31'b0, tbl[i].empty});
      chk($sformatf("tbl%0d_udf", i), {31'b0, udf_m}, {31'b0, tbl[i].udf});
    end

    // Fill to DEPTH, overflow, then read and write together while full.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b0, 1'b1, 8'($urandom), 1'b0);
      if (i == DEPTH - 2) chk("fill_not_full_31", {31'b0, full_m}, 32'd0);
      if (i == DEPTH - 1) chk("fill_full_32", {31'b0, full_m}, 32'd1);
      if (i == DEPTH - 1) chk("fill_no_ovf_32", {31'b0, ovf_m}, 32'd0);
      if (i == DEPTH)     chk("fill_ovf_33", {31'b0, ovf_m}, 32'd1);
    end
    step(1'b0, 1'b1, 8'h77, 1'b1);
    chk("full_rw_still_full", {31'b0, full_m}, 32'd1);
    chk("full_rw_ovf", {31'b0, ovf_m}, 32'd1);
    chk("full_rw_vld", {31'b0, vld_m}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("start_clears_ovf", {31'b0, ovf_m}, 32'd0);
    for (int i = 0; i < DEPTH * IN_W - 1; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", {31'b0, empty_m}, 32'd1);

    // Read of an empty FIFO with a same-cycle write: no bypass.
    do_reset();
    step(1'b0, 1'b1, 8'h5A, 1'b1);
    chk("rw_empty_udf", {31'b0, udf_m}, 32'd1);
    chk("rw_empty_vld", {31'b0, vld_m}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rw_next_vld", {31'b0, vld_m}, 32'd1);
    chk("rw_next_dout", {31'b0, dout_m}, 32'd0);

    // Framing: pulse on bit 16, then start after 4 bits of the second frame.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    lc = 0;
    lpos = 0;
    for (int i = 1; i <= FB; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (last_m) begin lc++; lpos = i; end
    end
    chk("frame1_pulses", lc, 32'd1);
    chk("frame1_pos", lpos, FB);
    lc = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (last_m) lc++;
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lpos = 0;
    for (int i = 1; i <= FB; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1);
      if (last_m) begin lc++; if (lpos == 0) lpos = i; end
    end
    chk("frame2_pulses", lc, 32'd1);
    chk("frame2_pos_after_start", lpos, FB);

    // Asynchronous reset mid-frame with 5 words stored.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_dout", {31'b0, dout_m}, 32'd0);
    chk("arst_vld", {31'b0, vld_m}, 32'd0);
    chk("arst_empty", {31'b0, empty_m}, 32'd1);
    chk("arst_full_flags", {29'b0, full_m, ovf_m, udf_m}, 32'd0);
    chk("arst_counts", {17'b0, bc_m, wc_m}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("arst_first_read_udf", {31'b0, udf_m}, 32'd1);

    // Randomized traffic in phases that fill, drain and balance the FIFO.
    do_reset();
    for (int ph = 0; ph < 9; ph++) begin
      case (ph % 3)
        0:       begin wp = 85; rp = 30; end
        1:       begin wp = 4;  rp = 95; end
        default: begin wp = 12; rp = 90; end
      endcase
      for (int i = 0; i < 180; i++) begin
        step(($urandom_range(99) < 2), ($urandom_range(99) < wp), 8'($urandom),
             ($urandom_range(99) < rp));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
